// File: rtl/rate_sched_pkg.sv
// Shared types and defaults for the modem clock-enable scheduler.
package rate_sched_pkg;
    localparam int DIV_W       = 4;
    localparam int DEF_SAM_DIV = 4;
    localparam int DEF_SPS     = 4;

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    // A divisor of zero would stall the counters; run it as divide-by-one.
    function automatic int unsigned clamp_div(input int unsigned d);
        return (d == 0) ? 1 : d;
    endfunction
endpackage

// File: rtl/rate_div_cnt.sv
// Modulo-N counter: counts 0..modulus-1 while adv is high, clr wins over adv.
// wrap flags the cycle in which an advance takes the count back to 0.
module rate_div_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         adv,
    input  logic [W-1:0] modulus,
    output logic [W-1:0] cnt,
    output logic         wrap
);
    logic [W-1:0] cnt_nxt;

    assign wrap = adv && (cnt >= modulus - W'(1));

    always_comb begin
        cnt_nxt = cnt;
        if (clr)
            cnt_nxt = '0;
        else if (wrap)
            cnt_nxt = '0;
        else if (adv)
            cnt_nxt = cnt + W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end
endmodule

// File: rtl/rate_sched.sv
// Sample/symbol clock-enable scheduler with glitch-free rate switching at symbol boundaries.
// Optional sys_clk2_en half-rate enable is built when RATE_SCHED_SYS2_EN is defined.
module rate_sched #(
    parameter int DIV_W       = rate_sched_pkg::DIV_W,
    parameter int SYM_CNT_W   = 8,
    parameter int DEF_SAM_DIV = rate_sched_pkg::DEF_SAM_DIV,
    parameter int DEF_SPS     = rate_sched_pkg::DEF_SPS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [DIV_W-1:0]     cfg_sam_div,
    input  logic [DIV_W-1:0]     cfg_sps,
    input  logic                 sync_req,
    output logic                 sam_clk_en,
    output logic                 sym_clk_en,
    output logic [DIV_W-1:0]     sam_phase,
    output logic [SYM_CNT_W-1:0] sym_cnt,
    output logic                 cfg_pend
`ifdef RATE_SCHED_SYS2_EN
    ,output logic                sys_clk2_en
`endif
);
    import rate_sched_pkg::*;

    state_t           state;
    logic [DIV_W-1:0] sam_div, sps, sh_sam_div, sh_sps;
    logic [DIV_W-1:0] new_sam_div, new_sps;
    logic [DIV_W-1:0] sc_cnt_unused, pc_nxt;
    logic             running, hs, restart, cnt_clr;
    logic             sc_wrap, pc_wrap, sam_d, sym_d;

    assign new_sam_div = DIV_W'(clamp_div(32'(cfg_sam_div)));
    assign new_sps     = DIV_W'(clamp_div(32'(cfg_sps)));

    assign running = (state != IDLE);
    assign hs      = cfg_valid && cfg_ready;
    // Counters restart on a sync, or right after the symbol that closes a pending config.
    assign restart = running && en && (sync_req || (state == PEND && sym_clk_en));
    assign cnt_clr = !running || !en || restart;

    rate_div_cnt #(.W(DIV_W)) u_sc (
        .clk     (clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .adv     (1'b1),
        .modulus (sam_div),
        .cnt     (sc_cnt_unused),
        .wrap    (sc_wrap)
    );

    rate_div_cnt #(.W(DIV_W)) u_pc (
        .clk     (clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .adv     (sam_clk_en),
        .modulus (sps),
        .cnt     (sam_phase),
        .wrap    (pc_wrap)
    );

    // sam_phase is the index of the sample being enabled, so the symbol
    // decision looks at the phase the next cycle will show.
    assign pc_nxt = pc_wrap ? '0 : sam_phase + DIV_W'(sam_clk_en);
    assign sam_d  = sc_wrap && !cnt_clr;
    assign sym_d  = sam_d && (pc_nxt == sps - DIV_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sam_div    <= DIV_W'(DEF_SAM_DIV);
            sps        <= DIV_W'(DEF_SPS);
            sh_sam_div <= DIV_W'(DEF_SAM_DIV);
            sh_sps     <= DIV_W'(DEF_SPS);
            sam_clk_en <= 1'b0;
            sym_clk_en <= 1'b0;
            sym_cnt    <= '0;
            cfg_pend   <= 1'b0;
            cfg_ready  <= 1'b1;
        end else begin
            sam_clk_en <= sam_d;
            sym_clk_en <= sym_d;
            sym_cnt    <= sym_cnt + SYM_CNT_W'(sym_d);
            case (state)
                IDLE: begin
                    if (hs) begin
                        sam_div <= new_sam_div;
                        sps     <= new_sps;
                    end
                    if (en)
                        state <= RUN;
                    cfg_ready <= 1'b1;
                end
                default: begin
                    if (!en || sync_req) begin
                        if (hs) begin
                            sam_div <= new_sam_div;
                            sps     <= new_sps;
                        end else if (state == PEND) begin
                            sam_div <= sh_sam_div;
                            sps     <= sh_sps;
                        end
                        cfg_pend  <= 1'b0;
                        cfg_ready <= 1'b1;
                        state     <= en ? RUN : IDLE;
                    end else if (state == PEND && sym_clk_en) begin
                        sam_div   <= sh_sam_div;
                        sps       <= sh_sps;
                        cfg_pend  <= 1'b0;
                        cfg_ready <= 1'b1;
                        state     <= RUN;
                    end else if (hs) begin
                        sh_sam_div <= new_sam_div;
                        sh_sps     <= new_sps;
                        cfg_pend   <= 1'b1;
                        cfg_ready  <= 1'b0;
                        state      <= PEND;
                    end
                end
            endcase
        end
    end

`ifdef RATE_SCHED_SYS2_EN
    always_ff @(posedge clk) begin
        if (reset || !en)
            sys_clk2_en <= 1'b0;
        else if (state == IDLE || sync_req)
            sys_clk2_en <= 1'b1;
        else
            sys_clk2_en <= ~sys_clk2_en;
    end
`endif
endmodule

// File: tb/tb_rate_sched.sv
// Directed bench for rate_sched: default rates, IDLE/RUN reconfiguration, sync, en drop, clamp, reset.
module tb_rate_sched;
    logic       clk = 1'b0;
    logic       reset, en, cfg_valid, sync_req;
    logic [3:0] cfg_sam_div, cfg_sps;
    logic       cfg_ready, sam_clk_en, sym_clk_en, cfg_pend;
    logic [3:0] sam_phase;
    logic [7:0] sym_cnt;
`ifdef RATE_SCHED_SYS2_EN
    logic       sys_clk2_en;
`endif

    int n_vec = 0;
    int n_err = 0;

    rate_sched dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_sam_div (cfg_sam_div),
        .cfg_sps     (cfg_sps),
        .sync_req    (sync_req),
        .sam_clk_en  (sam_clk_en),
        .sym_clk_en  (sym_clk_en),
        .sam_phase   (sam_phase),
        .sym_cnt     (sym_cnt),
        .cfg_pend    (cfg_pend)
`ifdef RATE_SCHED_SYS2_EN
        ,.sys_clk2_en(sys_clk2_en)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_en(input string tag, input logic s, input logic y);
        chk({tag, ".sam"}, 32'(sam_clk_en), 32'(s));
        chk({tag, ".sym"}, 32'(sym_clk_en), 32'(y));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; sync_req = 1'b0;
        cfg_sam_div = 4'd0; cfg_sps = 4'd0;
        step(); step();
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_pend", 32'(cfg_pend), 32'd0);
        chk_en("rst", 1'b0, 1'b0);
        chk("rst_phase", 32'(sam_phase), 32'd0);
        chk("rst_symcnt", 32'(sym_cnt), 32'd0);
`ifdef RATE_SCHED_SYS2_EN
        chk("rst_sys2", 32'(sys_clk2_en), 32'd0);
`endif
        reset = 1'b0;

        // Defaults 4/4: sample every 4 clk, symbol every 16, counted from first RUN cycle.
        en = 1'b1;
        step();
        chk_en("def_t0", 1'b0, 1'b0);
        for (int i = 1; i <= 48; i++) begin
            step();
            chk_en("def", (i % 4) == 0, (i % 16) == 0);
            if ((i % 4) == 0)
                chk("def_phase", 32'(sam_phase), 32'((i / 4 - 1) % 4));
        end
        chk("def_symcnt", 32'(sym_cnt), 32'd3);
        en = 1'b0;
        step();
        chk_en("idle", 1'b0, 1'b0);

        // IDLE reconfiguration 2/3, applied immediately.
        chk("idle_ready", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1; cfg_sam_div = 4'd2; cfg_sps = 4'd3; en = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk("idle_cfg_pend", 32'(cfg_pend), 32'd0);
        for (int i = 1; i <= 12; i++) begin
            step();
            chk_en("r23", (i % 2) == 0, (i % 6) == 0);
        end
        chk("r23_symcnt", 32'(sym_cnt), 32'd5);

        // RUN reconfiguration 1/8 offered at phase 1, applied after next symbol.
        step(); step(); step();
        chk("run_phase1", 32'(sam_phase), 32'd1);
        chk("run_ready", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1; cfg_sam_div = 4'd1; cfg_sps = 4'd8;
        step();
        cfg_valid = 1'b0;
        chk("pend_set", 32'(cfg_pend), 32'd1);
        chk("pend_ready", 32'(cfg_ready), 32'd0);
        chk_en("pend_t16", 1'b1, 1'b0);
        step();
        chk_en("pend_t17", 1'b0, 1'b0);
        step();
        chk_en("pend_sym", 1'b1, 1'b1);
        chk("pend_hold", 32'(cfg_pend), 32'd1);
        step();
        chk("applied_pend", 32'(cfg_pend), 32'd0);
        chk("applied_ready", 32'(cfg_ready), 32'd1);
        chk_en("switch", 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step();
            chk_en("r18", 1'b1, (i % 8) == 0);
            chk("r18_phase", 32'(sam_phase), 32'((i - 1) % 8));
        end
        chk("r18_symcnt", 32'(sym_cnt), 32'd8);

        // Back to 4/4 through IDLE, then sync at sc=2, pc=2.
        en = 1'b0;
        step();
        cfg_valid = 1'b1; cfg_sam_div = 4'd4; cfg_sps = 4'd4; en = 1'b1;
        step();
        cfg_valid = 1'b0;
        for (int i = 1; i <= 10; i++) step();
        chk("sync_pre_phase", 32'(sam_phase), 32'd2);
        sync_req = 1'b1;
        step();
        sync_req = 1'b0;
        chk_en("sync_next", 1'b0, 1'b0);
        chk("sync_phase", 32'(sam_phase), 32'd0);
`ifdef RATE_SCHED_SYS2_EN
        chk("sync_sys2", 32'(sys_clk2_en), 32'd1);
`endif
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_en("sync_gap", 1'b0, 1'b0);
        end
        step();
        chk_en("sync_first", 1'b1, 1'b0);
        chk("sync_symcnt", 32'(sym_cnt), 32'd8);

        // Pending 2/2 plus sync on the symbol-boundary decision cycle.
        step();
        cfg_valid = 1'b1; cfg_sam_div = 4'd2; cfg_sps = 4'd2;
        step();
        cfg_valid = 1'b0;
        chk("ps_pend", 32'(cfg_pend), 32'd1);
        for (int i = 1; i <= 9; i++) step();
        chk("ps_phase", 32'(sam_phase), 32'd3);
        sync_req = 1'b1;
        step();
        sync_req = 1'b0;
        chk_en("ps_suppr", 1'b0, 1'b0);
        chk("ps_pend_clr", 32'(cfg_pend), 32'd0);
        chk("ps_symcnt", 32'(sym_cnt), 32'd8);
        step(); chk_en("ps_t28", 1'b0, 1'b0);
        step(); chk_en("ps_t29", 1'b1, 1'b0);
        step(); chk_en("ps_t30", 1'b0, 1'b0);
        step(); chk_en("ps_t31", 1'b1, 1'b1);
        chk("ps_symcnt2", 32'(sym_cnt), 32'd9);

        // Pending 0/0 then en dropped mid-symbol: IDLE next cycle, shadow applied.
        cfg_valid = 1'b1; cfg_sam_div = 4'd0; cfg_sps = 4'd0;
        step();
        cfg_valid = 1'b0;
        chk("drop_pend", 32'(cfg_pend), 32'd1);
        en = 1'b0;
        step();
        chk_en("drop", 1'b0, 1'b0);
        chk("drop_pend_clr", 32'(cfg_pend), 32'd0);
        chk("drop_ready", 32'(cfg_ready), 32'd1);
        chk("drop_phase", 32'(sam_phase), 32'd0);

        // Divisors of zero run as 1/1: both enables every cycle.
        en = 1'b1;
        step();
        chk_en("clamp_t0", 1'b0, 1'b0);
`ifdef RATE_SCHED_SYS2_EN
        chk("clamp_sys2_t0", 32'(sys_clk2_en), 32'd1);
`endif
        for (int i = 1; i <= 6; i++) begin
            step();
            chk_en("clamp", 1'b1, 1'b1);
            chk("clamp_phase", 32'(sam_phase), 32'd0);
`ifdef RATE_SCHED_SYS2_EN
            chk("clamp_sys2", 32'(sys_clk2_en), 32'((i % 2) == 0));
`endif
        end
        chk("clamp_symcnt", 32'(sym_cnt), 32'd15);

        // Reset discards a pending config and restores 4/4.
        cfg_valid = 1'b1; cfg_sam_div = 4'd3; cfg_sps = 4'd5;
        step();
        cfg_valid = 1'b0;
        chk("rp_pend", 32'(cfg_pend), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rp_pend_clr", 32'(cfg_pend), 32'd0);
        chk("rp_ready", 32'(cfg_ready), 32'd1);
        chk("rp_symcnt", 32'(sym_cnt), 32'd0);
        chk_en("rp", 1'b0, 1'b0);
        step();
        for (int i = 1; i <= 4; i++) begin
            step();
            chk_en("rp_def", i == 4, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rate_sched.md
Name: rate_sched

Overview:
- Programmable clock-enable scheduler for the modem datapath.
- Runs entirely on clk, with no derived clocks. Generates the sample-rate enable (sam_clk_en) and the symbol-rate enable (sym_clk_en) consumed by the filters, upsamplers and slicers.
- Accepts runtime rate reconfiguration through a valid/ready handshake and applies it glitch-free at a symbol boundary.
- Accepts phase resynchronisation requests from the timing-recovery logic.

Parameters:
- DIV_W, 4: width of the clocks-per-sample and samples-per-symbol fields.
- SYM_CNT_W, 8: width of the free-running symbol counter.
- DEF_SAM_DIV, 4: clocks per sample loaded at reset.
- DEF_SPS, 4: samples per symbol loaded at reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  run request; low forces IDLE.
- cfg_valid  in  1  new rate configuration offered.
- cfg_ready  out  1  configuration can be accepted this cycle.
- cfg_sam_div  in  DIV_W  clocks per sample; 0 is treated as 1.
- cfg_sps  in  DIV_W  samples per symbol; 0 is treated as 1.
- sync_req  in  1  single-cycle pulse that realigns the sample and symbol phase to 0.
- sam_clk_en  out  1  single-cycle sample enable.
- sym_clk_en  out  1  single-cycle symbol enable; always coincident with a sam_clk_en.
- sam_phase  out  DIV_W  sample index within the current symbol.
- sym_cnt  out  SYM_CNT_W  symbols elapsed; wraps.
- cfg_pend  out  1  a configuration is accepted but not yet applied.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - Active divisors load DEF_SAM_DIV / DEF_SPS.
  - All counters clear to 0.
  - sam_clk_en=0, sym_clk_en=0, sam_phase=0, sym_cnt=0, cfg_pend=0.
  - cfg_ready=1 in the first cycle after reset.
- All outputs are registered.
- States: IDLE, RUN, PEND.
  - IDLE → RUN when en=1.
  - RUN → PEND on a config handshake.
  - PEND → RUN when the pending config is applied.
  - RUN or PEND → IDLE when en=0, effective in the next cycle.
- Clock counter sc runs 0..sam_div-1.
  - sam_clk_en=1 in the cycle sc wraps from sam_div-1 to 0.
  - First sam_clk_en occurs sam_div cycles after the first RUN cycle.
- Phase counter pc advances only on sam_clk_en and runs 0..sps-1.
  - sam_phase=pc.
  - sym_clk_en=1 together with sam_clk_en when pc==sps-1.
  - sym_cnt increments on each sym_clk_en and wraps to 0 after its maximum value.
- With the reset defaults (4/4): sam_clk_en every 4 clk, sym_clk_en every 16 clk.
- With divisor 1 (or 0): sam_clk_en is high every cycle.
- cfg_ready is 1 in IDLE and RUN and 0 in PEND. A handshake occurs when cfg_valid && cfg_ready.
  - Handshake in IDLE: the new values are active from the next cycle.
  - Handshake in RUN: values latch into shadow registers, cfg_pend=1, state goes to PEND.
  - In PEND the shadow values are applied in the cycle after sym_clk_en. sc and pc restart at 0 and cfg_pend clears in that same cycle.
- sync_req in RUN or PEND:
  - Next cycle: sc=0 and pc=0.
  - sam_clk_en and sym_clk_en are suppressed in the sync_req cycle.
  - sym_cnt is unchanged.
  - A pending config is applied at the sync point instead of waiting for the boundary.
- sync_req in IDLE is ignored.
- Simultaneous events:
  - sync_req and sym boundary in the same cycle: the sync takes priority and no sym_clk_en is issued.
  - en=0 with a pending config: the shadow values are applied on entry to IDLE and cfg_pend clears.
  - reset has priority over everything; a pending config is discarded.

Optional Feature:
- Macro RATE_SCHED_SYS2_EN.
- When defined, output port sys_clk2_en (1 bit) is added.
  - It is high on alternate clk cycles in RUN/PEND: 1 in the first RUN cycle, then toggling.
  - It is forced to 1 in the cycle after sync_req.
  - It is 0 in IDLE and after reset.
- When not defined, the port and its logic are absent and all other behaviour is identical.

Decomposition:
- Package rate_sched_pkg holds:
  - the state enum (IDLE, RUN, PEND);
  - DEF_SAM_DIV and DEF_SPS constants;
  - the DIV_W localparam;
  - a helper that clamps a divisor of 0 to 1.
- Sub-module rate_div_cnt: a modulo-N counter with clear, advance-enable and wrap pulse. Instantiated twice: once for sc (advance every cycle) and once for pc (advance on sam_clk_en).

Test Plan:
- Reset, then en=1 with defaults → first sam_clk_en after 4 cycles, then every 4 cycles; sym_clk_en every 16 cycles; sam_phase sequence 0,1,2,3; sym_cnt=3 after 48 cycles.
- In IDLE, config 2/3 → cfg_ready=1, applied immediately; with en=1, sam_clk_en every 2 cycles and sym_clk_en every 6 cycles.
- In RUN at pc=1, config 1/8:
  - cfg_pend=1 and cfg_ready=0 until the next sym_clk_en;
  - afterwards sam_clk_en every cycle and sym_clk_en every 8 cycles;
  - no runt or duplicate enable pulses at the switch.
- sync_req at sc=2, pc=2 → no enables that cycle, sam_phase=0 next cycle, next sam_clk_en 4 cycles later, sym_cnt unchanged.
- Config pending plus sync_req on the sym_clk_en cycle → sym_clk_en suppressed, new config applied, cfg_pend=0 next cycle; en dropped mid-symbol → IDLE next cycle, enables 0.
- cfg_sam_div=0, cfg_sps=0 → both treated as 1, so sam_clk_en and sym_clk_en are high every cycle. With RATE_SCHED_SYS2_EN defined, sys_clk2_en follows 1,0,1,0.
